// File: rtl/exec_pkg.sv
// Shared types for the execution unit.
//   op_t    : 3-bit operation codes presented on the op port
//   state_t : control FSM states (IDLE, MUL, WB)
package exec_pkg;

    typedef enum logic [2:0] {
        OpAdd = 3'b000,
        OpSub = 3'b001,
        OpAnd = 3'b010,
        OpOr  = 3'b011,
        OpXor = 3'b100,
        OpShl = 3'b101,
        OpShr = 3'b110,
        OpMul = 3'b111
    } op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        WB   = 2'd2
    } state_t;

endpackage

// File: rtl/mul_seq.sv
// Sequential shift-add multiplier, one multiplier bit per cycle.
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   start      : load operands a/b and begin an n-step multiply
//   a, b       : multiplicand and multiplier (n bits)
//   done       : high during the final step; product is valid alongside it
//   product    : 2n-bit product including the step being taken this cycle
module mul_seq #(
    parameter int unsigned n = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [n-1:0]   a,
    input  logic [n-1:0]   b,
    output logic           done,
    output logic [2*n-1:0] product
);

    localparam int unsigned CntW = $clog2(n) + 1;

    logic            run_q;
    logic [CntW-1:0] cnt_q;
    logic [2*n-1:0]  acc_q;
    logic [2*n-1:0]  mcand_q;
    logic [n-1:0]    mplier_q;
    logic [2*n-1:0]  sum;

    // Product is exposed combinationally so the last step's result can be
    // registered by the parent on the same edge the step completes.
    always_comb begin
        sum     = acc_q + (mplier_q[0] ? mcand_q : '0);
        product = sum;
        done    = run_q && (cnt_q == CntW'(n - 1));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            run_q    <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
        end else if (start) begin
            run_q    <= 1'b1;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= {{n{1'b0}}, a};
            mplier_q <= b;
        end else if (run_q) begin
            acc_q    <= sum;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + CntW'(1);
            run_q    <= !done;
        end
    end

endmodule

// File: rtl/exec_unit.sv
// Execution unit: single-cycle ALU plus sequential multiplier feeding a
// register-file write port.
// Ports:
//   clk, reset          : clock and synchronous active-high reset
//   in_valid / in_ready : operation handshake; accept when both high
//   op, rd, a, b        : operation code, destination, operands
//   w, Waddr, Wdata     : register-file write strobe/address/data
//   zero, carry         : flags of the last completed result
//   busy                : a multiply is in progress
module exec_unit
    import exec_pkg::*;
#(
    parameter int unsigned n = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [2:0]   op,
    input  logic [4:0]   rd,
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    output logic         w,
    output logic [4:0]   Waddr,
    output logic [n-1:0] Wdata,
    output logic         zero,
    output logic         carry,
    output logic         busy
);

    state_t         state_q, state_d;
    logic [4:0]     rd_q;
    logic           accept;
    logic           is_mul;
    logic           mul_start;
    logic           mul_done;
    logic [2*n-1:0] mul_prod;

    logic [n:0]     add_full;
    logic [n:0]     sub_full;
    logic [n:0]     shl_ext;
    logic [n:0]     shr_ext;
    logic [2:0]     shamt;
    logic [n-1:0]   alu_res;
    logic           alu_carry;

    logic           res_valid;
    logic [n-1:0]   res_data;
    logic           res_carry;
    logic [4:0]     res_addr;

    assign in_ready  = !reset && (state_q != MUL);
    assign accept    = in_valid && in_ready;
    assign is_mul    = (op_t'(op) == OpMul);
    assign mul_start = accept && is_mul;
    assign busy      = (state_q == MUL);

    mul_seq #(
        .n(n)
    ) u_mul_seq (
        .clk    (clk),
        .reset  (reset),
        .start  (mul_start),
        .a      (a),
        .b      (b),
        .done   (mul_done),
        .product(mul_prod)
    );

    // Single-cycle ALU. Shifts use one extra bit so the last bit shifted out
    // lands in a fixed position; a shift of 0 naturally leaves it clear.
    always_comb begin
        shamt     = b[2:0];
        add_full  = {1'b0, a} + {1'b0, b};
        sub_full  = {1'b0, a} - {1'b0, b};
        shl_ext   = {1'b0, a} << shamt;
        shr_ext   = {a, 1'b0} >> shamt;
        alu_res   = '0;
        alu_carry = 1'b0;
        case (op_t'(op))
            OpAdd: begin
                alu_res   = add_full[n-1:0];
                alu_carry = add_full[n];
            end
            OpSub: begin
                alu_res   = sub_full[n-1:0];
                alu_carry = sub_full[n];
            end
            OpAnd: alu_res = a & b;
            OpOr:  alu_res = a | b;
            OpXor: alu_res = a ^ b;
            OpShl: begin
                alu_res   = shl_ext[n-1:0];
                alu_carry = shl_ext[n];
            end
            OpShr: begin
                alu_res   = shr_ext[n:1];
                alu_carry = shr_ext[0];
            end
            default: begin
                alu_res   = '0;
                alu_carry = 1'b0;
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, WB: begin
                if (accept) begin
                    state_d = is_mul ? MUL : WB;
                end else begin
                    state_d = IDLE;
                end
            end
            MUL: begin
                if (mul_done) begin
                    state_d = WB;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Select which result (if any) retires on this edge.
    always_comb begin
        res_valid = 1'b0;
        res_data  = alu_res;
        res_carry = alu_carry;
        res_addr  = rd;
        if (state_q == MUL) begin
            res_valid = mul_done;
            res_data  = mul_prod[n-1:0];
            res_carry = |mul_prod[2*n-1:n];
            res_addr  = rd_q;
        end else begin
            res_valid = accept && !is_mul;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            rd_q    <= '0;
            w       <= 1'b0;
            Waddr   <= '0;
            Wdata   <= '0;
            zero    <= 1'b0;
            carry   <= 1'b0;
        end else begin
            state_q <= state_d;
            w       <= res_valid && (res_addr != 5'd0);
            if (mul_start) begin
                rd_q <= rd;
            end
            if (res_valid) begin
                zero  <= (res_data == '0);
                carry <= res_carry;
                // Writes to r0 are suppressed; address/data hold.
                if (res_addr != 5'd0) begin
                    Waddr <= res_addr;
                    Wdata <= res_data;
                end
            end
        end
    end

endmodule

// File: doc/exec_unit.md
EXEC_UNIT -- requirements
Module: exec_unit

Interface
REQ-001 The block SHALL have one parameter: n, default 8, the datapath width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port in_valid, input, 1 bit: an operation is presented.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the block can accept an operation this cycle.
REQ-006 The block SHALL have port op, input, 3 bits: operation code.
REQ-007 The block SHALL have port rd, input, 5 bits: destination register address.
REQ-008 The block SHALL have ports a and b, input, n bits each: operands, driven from register-file Rdata1 and Rdata2.
REQ-009 The block SHALL have port w, output, 1 bit: register-file write strobe.
REQ-010 The block SHALL have port Waddr, output, 5 bits: register-file write address.
REQ-011 The block SHALL have port Wdata, output, n bits: register-file write data.
REQ-012 The block SHALL have ports zero and carry, output, 1 bit each: result flags.
REQ-013 The block SHALL have port busy, output, 1 bit: a multiply is in progress.

Function
REQ-014 Accept SHALL occur on a rising edge where in_valid && in_ready; a, b, op and rd SHALL be captured only on accept.
REQ-015 The state machine SHALL have three states: IDLE, MUL and WB.
REQ-016 in_ready SHALL be 1 in IDLE and WB, and 0 in MUL and while reset is high.
REQ-017 On accept of a non-MUL op, the next state SHALL be WB, with Wdata, Waddr, zero and carry registered on that edge.
REQ-018 On accept of a MUL op (111), the next state SHALL be MUL.
REQ-019 From WB with no accept, the next state SHALL be IDLE; back-to-back single-cycle ops SHALL sustain one op per cycle.
REQ-020 Op encodings SHALL be: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL by b[2:0], 110 SHR (logical) by b[2:0], 111 MUL (low n bits).
REQ-021 carry SHALL be set as follows:
- ADD: carry-out.
- SUB: borrow (a < b, unsigned).
- SHL/SHR: last bit shifted out, or 0 for a shift of 0.
- Logic ops: 0.
- MUL: 1 if any bit of the 2n-bit product above n-1 is set.
REQ-022 zero SHALL be 1 iff the n-bit result is 0; results SHALL wrap modulo 2^n.
REQ-023 MUL SHALL be shift-add, one multiplier bit per cycle, for exactly n cycles in MUL, then WB.
REQ-024 Latency: w SHALL assert 1 cycle after accept for single-cycle ops and n+1 cycles after accept for MUL.
REQ-025 busy SHALL equal (state == MUL).
REQ-026 w SHALL be high for exactly one cycle per completed op (the WB cycle) and low otherwise.
REQ-027 When rd == 0, w SHALL stay 0, while zero and carry still update.
REQ-028 Waddr and Wdata SHALL hold their last values when w is 0.
REQ-029 in_valid asserted during MUL SHALL be ignored (no capture); the producer holds it.

Reset
REQ-030 While reset is high at a clock edge, the next state SHALL be IDLE, and w, Waddr, Wdata, zero, carry, busy and the multiply counter and accumulators SHALL all be 0.
REQ-031 Reset during MUL SHALL abandon the op with no write.
REQ-032 The first accept SHALL be possible on the first edge after reset deasserts.

Structure
REQ-033 Package exec_pkg SHALL hold the op_t enum (3-bit codes above) and the state_t enum (IDLE, MUL, WB).
REQ-034 The multiply datapath SHALL be one sub-module, mul_seq: start, operands, done, 2n-bit product, and a counter of clog2(n)+1 bits.
REQ-035 exec_unit SHALL contain the FSM, the single-cycle ALU and the output registers.

Verification
REQ-036 ADD a=8'hF0, b=8'h20, rd=3: the next cycle SHALL show w=1, Waddr=3, Wdata=8'h10, carry=1, zero=0.
REQ-037 SUB a=5, b=5, rd=7, followed immediately by XOR a=8'hAA, b=8'h55, rd=8 on the next cycle: the bench SHALL see two consecutive w pulses: first Wdata=0 with zero=1 and carry=0, then Wdata=8'hFF.
REQ-038 MUL a=12, b=11, rd=4 with n=8: busy and in_ready=0 SHALL hold for 8 cycles, then w=1 on cycle 9 with Wdata=8'h84 and carry=0; in_valid asserted during busy SHALL not be captured.
REQ-039 MUL a=8'h20, b=8'h10: Wdata SHALL be 8'h00, zero=1 and carry=1.
REQ-040 OR with rd=0: w SHALL stay 0 and zero/carry SHALL update; SHL a=8'h81, b=1 SHALL give Wdata=8'h02 and carry=1.
REQ-041 Reset asserted on MUL cycle 4: there SHALL be no w pulse, all outputs SHALL read 0, and in_ready SHALL be 1 on the first cycle after reset drops.
